// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings
// and the PC increment applied after every granted fetch.
package fetch_buffer_pkg;

  // Outstanding-fetch tracking. At most one request is in flight, so the
  // state alone records whether its response is wanted.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no fetch outstanding
    S_WAIT = 2'd1,  // one fetch outstanding, response will be kept
    S_DROP = 2'd2   // one fetch outstanding, response will be discarded
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO holding {pc, inst} pairs for the fetch unit.
// Push/pop/flush with an occupancy count and a combinational head read.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count_q gates its
    // visibility, and leaving it out of reset keeps it a plain RAM array.
    if (push_i && !flush_i && !rst) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch unit with a prefetch queue feeding IF/ID.
// Issues one word-aligned fetch at a time to the shared memory port (data
// side has arbitration priority), buffers {pc, inst} pairs in fetch_fifo,
// and flushes everything on a branch-resolution redirect.
// Optional feature: define FETCH_BYPASS_EN to present a kept response
// directly on the instruction outputs when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;

  logic            req_int;
  logic            issue;
  logic            keep_rsp;
  logic            bypass_hit;
  logic            head_valid;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;

  // Low address bits of a redirect target are dropped by word alignment.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(DEPTH));

  // A response is kept only when the fetch is still wanted and no redirect hits.
  assign keep_rsp = (state_q == S_WAIT) && mem_rvalid && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = keep_rsp && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Head selection: the in-flight response when bypassing, else the FIFO head.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    head_valid = !fifo_empty;
    head_pc    = fifo_head[2*XLEN-1:XLEN];
    head_inst  = fifo_head[XLEN-1:0];
    if (bypass_hit) begin
      head_valid = 1'b1;
      head_pc    = pending_pc_q;
      head_inst  = mem_rdata;
    end
  end

  // A redirect suppresses both queue movements; a bypassed word consumed by
  // IF/ID never enters the queue.
  assign fifo_pop  = head_valid && id_ready && !redirect_valid && !fifo_empty;
  assign fifo_push = keep_rsp && !(bypass_hit && id_ready);

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .wdata_i ({pending_pc_q, mem_rdata}),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  // Fetch FSM state and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // Next-state logic: issue when idle with room, track the single outstanding
  // fetch, and let a redirect retarget fetch_pc from any state.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    req_int      = (state_q == S_IDLE) && !fifo_full && !redirect_valid;
    issue        = req_int && mem_gnt;

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          pending_pc_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + XLEN'(PC_INC);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid)          state_d = S_IDLE;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  // Outputs are forced to their reset values while rst is asserted.
  assign mem_req    = req_int && !rst;
  assign mem_addr   = rst ? RESET_PC : fetch_pc_q;
  assign inst_valid = head_valid && !rst;
  assign inst       = rst ? '0 : head_inst;
  assign inst_pc    = rst ? '0 : head_pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer (DEPTH=4, RESET_PC=0): a cycle table
// covering issue, stall, redirect-drop and redirect-with-rvalid, plus
// hand-written streaming, queue-full, grant-stall/wrap and mid-fetch reset.
module tb_fetch_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            id_ready;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_buffer #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents as seen by the fetch unit.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_5A00;
  endfunction

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic gnt,
                      input logic rvalid, input logic [31:0] rdata, input logic ready);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_gnt        = gnt;
    mem_rvalid     = rvalid;
    mem_rdata      = rdata;
    id_ready       = ready;
    #1;
  endtask

  // One reset cycle, checking outputs while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_gnt        = 1'b1;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'hFFFF_FFFF;
    id_ready       = 1'b1;
    #1;
    check("rst mem_req", {31'b0, mem_req}, 32'h0);
    check("rst inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst inst", inst, 32'h0);
    check("rst inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_gnt = 1'b0;
  endtask

  // Free-running memory with 1-cycle response latency. id_ready held low for
  // `hold` cycles, then pops are checked against an incrementing PC from 0.
  task automatic run_stream(input int hold, input int n_pops, input string tag);
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          pops;
    int          cyc;
    pend = 1'b0; pend_addr = '0; exp_pc = '0; pops = 0; cyc = 0;
    while (pops < n_pops && cyc < 300) begin
      step(1'b0, 32'h0, 1'b1, pend, pend ? mem_word(pend_addr) : 32'h0, cyc >= hold);
      if (hold > 0 && cyc == hold - 1) begin
        check({tag, " full mem_req"}, {31'b0, mem_req}, 32'h0);
        check({tag, " full inst_valid"}, {31'b0, inst_valid}, 32'h1);
        check({tag, " full head pc"}, inst_pc, 32'h0);
        check({tag, " full mem_addr"}, mem_addr, 32'h10);
      end
      if (inst_valid && id_ready) begin
        check($sformatf("%s pop%0d pc", tag, pops), inst_pc, exp_pc);
        check($sformatf("%s pop%0d inst", tag, pops), inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      pend      = mem_req && mem_gnt;
      pend_addr = mem_addr;
      cyc++;
    end
    if (pops < n_pops) check({tag, " pop budget"}, pops, n_pops);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    id_ready       = 1'b0;

    //            redir rpc           gnt rv  rdata          rdy  req addr           vld      pc            inst
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,   1'b0,    32'h0,   32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h4,   BYP,     32'h0,   32'h1111_0000};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,   1'b1,    32'h0,   32'h1111_0000};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h2222_0000, 1'b0, 1'b0, 32'h8,   1'b1,    32'h0,   32'h1111_0000};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,   1'b1,    32'h0,   32'h1111_0000};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,   1'b1,    32'h0,   32'h1111_0000};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,   1'b1,    32'h4,   32'h2222_0000};
    vecs[7]  = '{1'b1, 32'h103,      1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,   1'b1,    32'h4,   32'h2222_0000};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0,    32'h0,   32'h0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0,    32'h0,   32'h0};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h100, 1'b0,    32'h0,   32'h0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0,    32'h0,   32'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h3333_0000, 1'b1, 1'b0, 32'h104, BYP,     32'h100, 32'h3333_0000};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104, !BYP,    32'h100, 32'h3333_0000};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104, 1'b0,    32'h0,   32'h0};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104, 1'b0,    32'h0,   32'h0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h4444_0000, 1'b0, 1'b0, 32'h108, BYP,     32'h104, 32'h4444_0000};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h108, 1'b1,    32'h104, 32'h4444_0000};
    vecs[18] = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h10C, 1'b1,    32'h104, 32'h4444_0000};
    vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0,    32'h0,   32'h0};

    // Table: issue/response, grant stall, redirect drop, redirect with rvalid+pop.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
      check($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].exp_pc);
        check($sformatf("v%0d inst", i), inst, vecs[i].exp_inst);
      end
    end

    // Free-running fetch with id_ready always high.
    do_reset();
    run_stream(0, 12, "stream");

    // Queue fills to DEPTH under a 20-cycle stall, then drains in order.
    do_reset();
    run_stream(20, 8, "full");

    // Grant held low for 10 cycles at the top of the address space, then wrap.
    do_reset();
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap redirect mem_req", {31'b0, mem_req}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      check($sformatf("stall%0d mem_req", i), {31'b0, mem_req}, 32'h1);
      check($sformatf("stall%0d mem_addr", i), mem_addr, 32'hFFFF_FFFC);
      check($sformatf("stall%0d inst_valid", i), {31'b0, inst_valid}, 32'h0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap grant mem_addr", mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0A0_0001, 1'b0);
    check("wrap next mem_addr", mem_addr, 32'h0);
    check("wrap rvalid inst_valid", {31'b0, inst_valid}, {31'b0, BYP});
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap head valid", {31'b0, inst_valid}, 32'h1);
    check("wrap head pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap head inst", inst, 32'hA0A0_0001);
    check("wrap resume mem_req", {31'b0, mem_req}, 32'h1);

    // Reset while a fetch is outstanding returns to idle at RESET_PC.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst grant mem_req", {31'b0, mem_req}, 32'h1);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst mem_req", {31'b0, mem_req}, 32'h1);
    check("midrst mem_addr", mem_addr, 32'h0);
    check("midrst inst_valid", {31'b0, inst_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch unit with a prefetch queue. It sits directly upstream of the IF/ID pipeline register and drives the instruction-side request of the shared single-port memory. It takes the place of the clock-phase memory multiplexing. Data-side accesses win memory arbitration, so fetch only proceeds when granted. Fetched instructions are buffered with their PCs, and the whole queue is flushed on a control-flow redirect from branch resolution.

## Interface
Parameters:
- XLEN, 32, address/instruction width
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- mem_req  out  1  instruction fetch request
- mem_addr  out  XLEN  fetch address (word aligned)
- mem_gnt  in  1  request accepted this cycle (arbiter: data port priority)
- mem_rvalid  in  1  fetch data valid, ≥1 cycle after mem_gnt
- mem_rdata  in  XLEN  fetched instruction word
- inst_valid  out  1  head entry valid
- inst  out  XLEN  head instruction
- inst_pc  out  XLEN  PC of head instruction
- id_ready  in  1  IF/ID accepts head this cycle (low = stall/freeze)

## Operation
- Registers: fetch_pc, FIFO of {pc, inst}, count (0..DEPTH), 2-bit FSM.
- FSM states:
  - S_IDLE: no outstanding fetch.
  - S_WAIT: one fetch outstanding; response is kept.
  - S_DROP: one fetch outstanding; response is discarded.
- Maximum one outstanding request.
- mem_req = (state==S_IDLE) && count<DEPTH && !redirect_valid. mem_addr = fetch_pc.
- S_IDLE & mem_req & mem_gnt: latch addr as pending_pc, fetch_pc += 4 (mod 2^XLEN, wraps 0xFFFFFFFC→0), go to S_WAIT.
- S_WAIT & mem_rvalid & !redirect_valid: push {pending_pc, mem_rdata}, go to S_IDLE.
- S_WAIT & redirect_valid & !mem_rvalid: go to S_DROP.
- S_WAIT & redirect_valid & mem_rvalid: discard the data, go to S_IDLE.
- S_DROP & mem_rvalid: discard the data, go to S_IDLE. A redirect while in S_DROP only updates fetch_pc.
- Pop when inst_valid && id_ready && !redirect_valid.
- Push and pop in the same cycle: count unchanged.
- Full: count==DEPTH, so no request. A push can never occur while full, because issue requires count<DEPTH and only one fetch is outstanding.
- Redirect has priority over all other actions in its cycle:
  - count←0, head/tail pointers←0.
  - fetch_pc←{redirect_pc[XLEN-1:2],2'b00}.
  - No pop and no push in that cycle.
- inst_valid = count!=0. inst/inst_pc read combinationally from the head entry. inst/inst_pc are don't-care when inst_valid=0.

## Timing
- Reset: state S_IDLE, count 0, fetch_pc RESET_PC.
- Output values while rst is high: mem_req 0, inst_valid 0, mem_addr RESET_PC, inst 0, inst_pc 0.
- Reset applied mid-fetch returns to S_IDLE. The memory must not assert mem_rvalid after rst for a pre-reset request; the arbiter resets on the same rst.
- Redirect at cycle T, grant at T+1, rvalid at T+2: head valid at T+3 without bypass, T+2 with bypass.
- Steady-state throughput: 1 instruction per 2 cycles for 1-cycle memory latency (issue, response).
- mem_gnt low stalls issue indefinitely. mem_req stays high and mem_addr stays stable until granted or redirected.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count==0 and a response is kept (S_WAIT, rvalid, no redirect), inst_valid=1 with inst=mem_rdata and inst_pc=pending_pc in the same cycle.
  - If id_ready is also high, the entry is consumed and not pushed; otherwise it is pushed.
- FETCH_BYPASS_EN undefined: responses always go through the FIFO, adding 1 cycle of latency.

## Structure
- The shared defines file holds the FSM state encodings (S_IDLE/S_WAIT/S_DROP) and the PC increment constant (4).
- One sub-module: fetch_fifo, a synchronous FIFO of width 2·XLEN and depth DEPTH with push/pop/flush/count and a combinational head read. fetch_buffer instantiates it once.

## Test plan
- Reset then free-running grant, 1-cycle rvalid, id_ready=1 -> inst_pc sequence 0x0,0x4,0x8,…, each instruction matches memory contents, no duplicates or gaps.
- id_ready=0 for 20 cycles -> exactly DEPTH=4 entries buffered (PCs 0x0–0xC), mem_req=0 while full. Release -> in-order drain, then fetching resumes at 0x10.
- Redirect to 0x103 while in S_WAIT, rvalid 3 cycles later -> stale data dropped, next inst_pc=0x100, queue empty in the cycle after the redirect.
- Redirect in the same cycle as rvalid and a pop -> nothing pushed or popped, count 0, next mem_addr=0x100.
- mem_gnt held low 10 cycles (data port busy) -> mem_req high with mem_addr stable throughout, no FIFO change. Fetch at 0xFFFFFFFC -> next mem_addr wraps to 0x0.
- FETCH_BYPASS_EN on, empty queue, rvalid with id_ready=1 -> inst_valid in the same cycle and count stays 0. With the macro off -> inst_valid one cycle later.
